calc_ctrl: RTL and testbench
============================

CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 Parameter: N, default 8, operand/result width; SHALL be legal only for 1 <= N <= 8, with bytes zero-extended/truncated to N.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 rx_data  input  8  command byte from UART receiver.
REQ-005 rx_valid  input  1  rx_data valid.
REQ-006 rx_ready  output  1  controller accepts rx_data.
REQ-007 tx_data  output  8  response byte to UART transmitter.
REQ-008 tx_valid  output  1  tx_data valid.
REQ-009 tx_ready  input  1  transmitter accepts tx_data.
REQ-010 alu_op  output  4  opcode to ALU.
REQ-011 alu_a, alu_b  output  N each  ALU operands.
REQ-012 alu_y  input  N  ALU result.
REQ-013 alu_flg  input  1  ALU zero-compare flag (a-b==0).
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 err  output  1  sticky illegal-opcode indicator.

Function
REQ-016 A byte transfer SHALL occur only in a cycle where valid and ready are both high.
REQ-017 FSM states SHALL be IDLE, GET_A, GET_B, EXEC, SEND_Y, SEND_F.
REQ-018 IDLE: rx_ready=1; byte with rx_data[7:4]==4'hA SHALL latch alu_op=rx_data[3:0], clear err, go to GET_A; any other byte SHALL be consumed and discarded, staying in IDLE.
REQ-019 GET_A: rx_ready=1; on transfer, alu_a=rx_data[N-1:0], go to GET_B.
REQ-020 GET_B: rx_ready=1; on transfer, alu_b=rx_data[N-1:0], go to EXEC.
REQ-021 EXEC: rx_ready=0; exactly one cycle; SHALL register alu_y and alu_flg; SHALL set err if alu_op[3]==1 (ALU returns 0); go to SEND_Y.
REQ-022 SEND_Y: tx_valid=1, tx_data=registered result zero-extended to 8 bits; on tx_ready go to SEND_F (macro defined) or IDLE.
REQ-023 SEND_F: tx_valid=1, tx_data={7'b0, registered flag}; on tx_ready go to IDLE.
REQ-024 Latency: tx_valid SHALL rise exactly 2 cycles after the operand-B transfer cycle.
REQ-025 tx_data SHALL remain stable while tx_valid=1 and tx_ready=0; tx_valid SHALL not drop before acceptance.
REQ-026 rx_ready SHALL be 0 in EXEC, SEND_Y and SEND_F; rx bytes arriving then are not consumed (UART side buffers them).
REQ-027 alu_op/alu_a/alu_b SHALL hold their values from capture until overwritten by the next command.
REQ-028 tx_ready asserted outside SEND states SHALL have no effect.

Reset
REQ-029 On rst_n=0, immediately: state=IDLE, rx_ready=1 (IDLE), tx_valid=0, tx_data=0, alu_op=0, alu_a=0, alu_b=0, busy=0, err=0, result/flag registers=0.
REQ-030 Reset mid-command SHALL abandon the partial command; no response byte is sent afterwards.

Configuration
REQ-031 Macro CALC_FLAG_BYTE_EN: when defined, SEND_F exists and every command returns 2 bytes (result, flag); when undefined, SEND_F is absent, SEND_Y returns to IDLE and every command returns 1 byte.

Verification
REQ-032 Bytes 0xA0,0x05,0x03 -> tx 0x08 then (macro) 0x00; err=0.
REQ-033 Bytes 0xA1,0x07,0x07 -> tx 0x00 then (macro) 0x01.
REQ-034 Bytes 0x55,0xA4,0x0F,0x3C -> 0x55 discarded; tx 0x33; busy rises after 0xA4.
REQ-035 Bytes 0xA9,0x01,0x02 -> tx 0x00, err=1 until next valid header accepted.
REQ-036 Bytes 0xA5,0x01,0x03 with tx_ready held low 5 cycles -> tx_valid=1 and tx_data=0x08 stable for all 5 cycles, single transfer on release.
REQ-037 rst_n pulsed low after 0xA0,0x05 -> all outputs at reset values; next 0xA3,0x0C,0x03 -> tx 0x0F.

Source files
------------

// File: rtl/calc_ctrl.sv
// Byte-oriented calculator controller: header, operand A, operand B, one ALU cycle, response.
// Define CALC_FLAG_BYTE_EN to send the compare flag as a second response byte.
module calc_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [3:0]   alu_op,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  input  logic [N-1:0] alu_y,
  input  logic         alu_flg,
  output logic         busy,
  output logic         err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] GET_A  = 3'd1;
  localparam logic [2:0] GET_B  = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] SEND_Y = 3'd4;
`ifdef CALC_FLAG_BYTE_EN
  localparam logic [2:0] SEND_F = 3'd5;
`endif

  logic [2:0]   state;
  logic [N-1:0] y_r;
  logic         f_r;
  logic         rx_xfer;
  logic         tx_xfer;

  assign rx_ready = (state == IDLE) || (state == GET_A) || (state == GET_B);
  assign busy     = (state != IDLE);
  assign rx_xfer  = rx_valid && rx_ready;
  assign tx_xfer  = tx_valid && tx_ready;

`ifdef CALC_FLAG_BYTE_EN
  assign tx_valid = (state == SEND_Y) || (state == SEND_F);
`else
  assign tx_valid = (state == SEND_Y);
`endif

  // Response byte comes straight from registered state, so it is stable while stalled.
  always_comb begin
    tx_data = '0;
    if (state == SEND_Y) tx_data[N-1:0] = y_r;
`ifdef CALC_FLAG_BYTE_EN
    else if (state == SEND_F) tx_data[0] = f_r;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      alu_op <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      y_r    <= '0;
      f_r    <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (rx_xfer && rx_data[7:4] == 4'hA) begin
          alu_op <= rx_data[3:0];
          err    <= 1'b0;
          state  <= GET_A;
        end
        GET_A: if (rx_xfer) begin
          alu_a <= rx_data[N-1:0];
          state <= GET_B;
        end
        GET_B: if (rx_xfer) begin
          alu_b <= rx_data[N-1:0];
          state <= EXEC;
        end
        EXEC: begin
          y_r   <= alu_y;
          f_r   <= alu_flg;
          if (alu_op[3]) err <= 1'b1;
          state <= SEND_Y;
        end
`ifdef CALC_FLAG_BYTE_EN
        SEND_Y: if (tx_xfer) state <= SEND_F;
        SEND_F: if (tx_xfer) state <= IDLE;
`else
        SEND_Y: if (tx_xfer) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl with a behavioural ALU and a response scoreboard.
module tb_calc_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [3:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_y;
  logic       alu_flg;
  logic       busy, err;

  int npass = 0;
  int ntot  = 0;
  logic [7:0] exp_q[$];

  calc_ctrl #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_flg(alu_flg), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return a << b;
      4'h6: return a >> b;
      4'h7: return ~a;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_y   = alu_fn(alu_op, alu_a, alu_b);
  assign alu_flg = ((alu_a - alu_b) == 8'h00);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntot++;
    assert (obs === expv) npass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  // Response monitor: every accepted tx byte must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      chk("tx_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic push_exp(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_q.push_back(op[3] ? 8'h00 : alu_fn(op, a, b));
`ifdef CALC_FLAG_BYTE_EN
    exp_q.push_back({7'b0, a == b});
`endif
  endtask

  // Full command with the two-cycle response latency checked after operand B.
  task automatic cmd(input logic [7:0] h, input logic [7:0] a, input logic [7:0] b);
    send_byte(h);
    send_byte(a);
    push_exp(h[3:0], a, b);
    send_byte(b);
    chk("lat_exec_no_tx", 32'(tx_valid), 32'd0);
    chk("lat_exec_no_rx", 32'(rx_ready), 32'd0);
    @(negedge clk);
    chk("lat_tx_valid", 32'(tx_valid), 32'd1);
    wait_idle();
  endtask

  initial begin
    rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_outs", {tx_data, alu_op, 3'b0, err, alu_a, alu_b}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    cmd(8'hA0, 8'h05, 8'h03);
    chk("add_err", 32'(err), 32'd0);
    chk("hold_ops", {12'b0, alu_op, alu_a, alu_b}, {12'b0, 4'h0, 8'h05, 8'h03});

    cmd(8'hA1, 8'h07, 8'h07);

    // Non-header byte is dropped; header makes the controller busy.
    send_byte(8'h55);
    chk("discard_busy", 32'(busy), 32'd0);
    send_byte(8'hA4);
    chk("hdr_busy", 32'(busy), 32'd1);
    send_byte(8'h0F);
    push_exp(4'h4, 8'h0F, 8'h3C);
    send_byte(8'h3C);
    wait_idle();

    cmd(8'hA9, 8'h01, 8'h02);
    chk("illegal_err", 32'(err), 32'd1);
    send_byte(8'h77);
    chk("err_sticky", 32'(err), 32'd1);

    // Stalled transmitter: response must hold for five cycles, then go once.
    send_byte(8'hA5);
    chk("err_cleared", 32'(err), 32'd0);
    send_byte(8'h01);
    tx_ready = 1'b0;
    push_exp(4'h5, 8'h01, 8'h03);
    send_byte(8'h03);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(tx_valid), 32'd1);
      chk("stall_data", 32'(tx_data), 32'h08);
    end
    tx_ready = 1'b1;
    wait_idle();
    chk("stall_single", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a command discards it.
    send_byte(8'hA0);
    send_byte(8'h05);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_outs", {tx_data, alu_op, 3'b0, err, alu_a, alu_b}, 32'd0);
    chk("mid_rst_ready", {30'b0, rx_ready, tx_valid}, 32'd2);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_rst_quiet", 32'(tx_valid), 32'd0);
    cmd(8'hA3, 8'h0C, 8'h03);

    // Stray tx_ready in IDLE changes nothing.
    repeat (3) @(negedge clk);
    chk("idle_tx_ready", {30'b0, busy, tx_valid}, 32'd0);
    chk("q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
